// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, exception flush/redirect,
// and a stall watchdog with a saturating stalled-cycle counter.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        timeout_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {S_IDLE, S_RECOVER} state_t;

  localparam logic [15:0] RUN_MAX   = 16'(WDOG_LIMIT - 1);
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_stalled;
  logic [15:0] r_run_len;
  logic        r_timeout;
  logic [31:0] r_stall_cycles;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc_run(input logic [15:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Exceptions are only honoured in IDLE; RECOVER masks them for one cycle.
  always_comb begin
    w_next   = r_state;
    w_flush  = 1'b0;
    w_stall  = 6'b000000;
    w_new_pc = 32'h0;
    if (r_state == S_IDLE && excepttype_i != 32'h0) begin
      w_flush  = 1'b1;
      w_next   = S_RECOVER;
      w_new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end else begin
      if (r_state == S_RECOVER) w_next = S_IDLE;
      if (stallreq_from_mem)      w_stall = 6'b011111;
      else if (stallreq_from_ex)  w_stall = 6'b001111;
      else if (stallreq_from_id)  w_stall = 6'b000111;
      else if (stallreq_from_if)  w_stall = 6'b000111;
    end
    if (rst) begin
      w_flush  = 1'b0;
      w_stall  = 6'b000000;
      w_new_pc = 32'h0;
    end
  end

  assign w_stalled = |w_stall;

  // Watchdog: the set condition takes precedence over a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_len      <= 16'd0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (w_stalled) begin
        r_run_len      <= sat_inc_run(r_run_len);
        r_stall_cycles <= sat_inc32(r_stall_cycles);
      end else begin
        r_run_len      <= 16'd0;
      end
      if (w_stalled && r_run_len == RUN_MAX) r_timeout <= 1'b1;
      else if (timeout_clr)                  r_timeout <= 1'b0;
    end
  end

  assign stall         = w_stall;
  assign flush         = w_flush;
  assign new_pc        = w_new_pc;
  assign stall_timeout = r_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule
